// File: rtl/mem_arbiter_ctrl_if.sv
// Requester and RAM signals of the fetch/data byte-RAM arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface mem_arbiter_ctrl_if;
  logic        I_REQ;
  logic [10:0] I_ADDR;
  logic        I_DONE;
  logic        I_ERR;
  logic [31:0] I_RDATA;
  logic        D_REQ;
  logic        D_WR;
  logic        D_UNSIGNED;
  logic [1:0]  D_SIZE;
  logic [10:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_DONE;
  logic        D_ERR;
  logic [31:0] D_RDATA;
  logic        RAM_RE;
  logic        RAM_WE;
  logic [10:0] RAM_RADDR;
  logic [10:0] RAM_WADDR;
  logic [7:0]  RAM_WDATA;
  logic [7:0]  RAM_RDATA;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WR, D_UNSIGNED, D_SIZE, D_ADDR, D_WDATA, RAM_RDATA,
    output I_DONE, I_ERR, I_RDATA, D_DONE, D_ERR, D_RDATA,
    output RAM_RE, RAM_WE, RAM_RADDR, RAM_WADDR, RAM_WDATA
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WR, D_UNSIGNED, D_SIZE, D_ADDR, D_WDATA, RAM_RDATA,
    input  I_DONE, I_ERR, I_RDATA, D_DONE, D_ERR, D_RDATA,
    input  RAM_RE, RAM_WE, RAM_RADDR, RAM_WADDR, RAM_WDATA
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter between an instruction-fetch port and a data port sharing
// one byte-wide synchronous RAM; multi-byte transfers are serialised little-endian.
//   state | meaning
//   IDLE  | sample requests, grant, issue first RAM access or flag an error
//   READ  | RAM_RE asserted for byte r_cnt, previous byte captured
//   DRAIN | capture the last read byte
//   WRITE | RAM_WE asserted for byte r_cnt
//   RESP  | one-cycle DONE/ERR on the granted port
module mem_arbiter_ctrl #(
  parameter int unsigned MEM_BYTES = 1536
) (
  input logic               CLK,
  input logic               RST_N,
  mem_arbiter_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_RESP} state_t;
  localparam logic [12:0] LP_MEM_BYTES = 13'(MEM_BYTES);

  state_t      r_state, w_state_nxt;
  logic        r_last_d, r_gnt_d, r_wr, r_uns, r_err;
  logic [10:0] r_addr;
  logic [1:0]  r_last_idx, r_cnt;
  logic [31:0] r_wdata, r_buf;
  logic        r_ram_re, r_ram_we;
  logic [10:0] r_ram_raddr, r_ram_waddr;
  logic [7:0]  r_ram_wdata;
  logic        r_i_done, r_i_err, r_d_done, r_d_err;
  logic [31:0] r_i_rdata, r_d_rdata;

  logic        w_any, w_gnt_d, w_g_wr, w_g_err;
  logic [10:0] w_g_addr;
  logic [1:0]  w_g_size, w_g_last_idx;
  logic [12:0] w_g_end;

  // D wins a tie unless it was the last port served
  assign w_any    = bus.I_REQ | bus.D_REQ;
  assign w_gnt_d  = bus.D_REQ & (~bus.I_REQ | ~r_last_d);
  assign w_g_addr = w_gnt_d ? bus.D_ADDR : bus.I_ADDR;
  assign w_g_size = w_gnt_d ? bus.D_SIZE : 2'b10;
  assign w_g_wr   = w_gnt_d & bus.D_WR;

  always_comb begin
    w_g_last_idx = 2'd3;
    case (w_g_size)
      2'b00:   w_g_last_idx = 2'd0;
      2'b01:   w_g_last_idx = 2'd1;
      default: w_g_last_idx = 2'd3;
    endcase
  end

  assign w_g_end = {2'b00, w_g_addr} + {11'd0, w_g_last_idx};
  assign w_g_err = (w_g_size == 2'b11) | ({2'b00, w_g_addr} >= LP_MEM_BYTES) |
                   (w_g_end >= LP_MEM_BYTES);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = w_g_err ? S_RESP : (w_g_wr ? S_WRITE : S_READ);
      S_READ:  if (r_cnt == r_last_idx) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_RESP;
      S_WRITE: if (r_cnt == r_last_idx) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic        w_cap, w_rsp_d, w_rsp_err, w_rsp_wr, w_enter_resp;
  logic [1:0]  w_cap_idx, w_cnt_inc;
  logic [10:0] w_nxt_addr;
  logic [31:0] w_buf_nxt, w_ext;

  // RAM data arrives one cycle after RE, so READ captures the previous byte
  assign w_cap     = ((r_state == S_READ) && (r_cnt != 2'd0)) || (r_state == S_DRAIN);
  assign w_cap_idx = (r_state == S_DRAIN) ? r_last_idx : (r_cnt - 2'd1);
  assign w_cnt_inc = r_cnt + 2'd1;
  assign w_nxt_addr = r_addr + {9'd0, r_cnt} + 11'd1;

  always_comb begin
    w_buf_nxt = r_buf;
    if (w_cap) w_buf_nxt[{w_cap_idx, 3'b000} +: 8] = bus.RAM_RDATA;
  end

  always_comb begin
    w_ext = w_buf_nxt;
    case (r_last_idx)
      2'd0:    w_ext = {{24{~r_uns & w_buf_nxt[7]}}, w_buf_nxt[7:0]};
      2'd1:    w_ext = {{16{~r_uns & w_buf_nxt[15]}}, w_buf_nxt[15:0]};
      default: w_ext = w_buf_nxt;
    endcase
  end

  assign w_rsp_d      = (r_state == S_IDLE) ? w_gnt_d : r_gnt_d;
  assign w_rsp_err    = (r_state == S_IDLE) ? w_g_err : r_err;
  assign w_rsp_wr     = (r_state == S_IDLE) ? w_g_wr  : r_wr;
  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  logic        w_re_nxt, w_we_nxt;
  logic [10:0] w_raddr_nxt, w_waddr_nxt;
  logic [7:0]  w_wdata_nxt;

  always_comb begin
    w_re_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    w_raddr_nxt = r_ram_raddr;
    w_waddr_nxt = r_ram_waddr;
    w_wdata_nxt = r_ram_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_any && !w_g_err) begin
          if (w_g_wr) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_g_addr;
            w_wdata_nxt = bus.D_WDATA[7:0];
          end else begin
            w_re_nxt    = 1'b1;
            w_raddr_nxt = w_g_addr;
          end
        end
      end
      S_READ: begin
        if (r_cnt != r_last_idx) begin
          w_re_nxt    = 1'b1;
          w_raddr_nxt = w_nxt_addr;
        end
      end
      S_WRITE: begin
        if (r_cnt != r_last_idx) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_nxt_addr;
          w_wdata_nxt = r_wdata[{w_cnt_inc, 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last_d   <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_wr       <= 1'b0;
      r_uns      <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_last_idx <= '0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_last_d   <= w_gnt_d;
        r_gnt_d    <= w_gnt_d;
        r_wr       <= w_g_wr;
        r_uns      <= w_gnt_d & bus.D_UNSIGNED;
        r_err      <= w_g_err;
        r_addr     <= w_g_addr;
        r_last_idx <= w_g_last_idx;
        r_cnt      <= 2'd0;
        r_wdata    <= w_gnt_d ? bus.D_WDATA : 32'd0;
      end else if (r_state == S_READ || r_state == S_WRITE) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_raddr <= '0;
      r_ram_waddr <= '0;
      r_ram_wdata <= '0;
      r_i_done    <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_err     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_ram_re    <= w_re_nxt;
      r_ram_we    <= w_we_nxt;
      r_ram_raddr <= w_raddr_nxt;
      r_ram_waddr <= w_waddr_nxt;
      r_ram_wdata <= w_wdata_nxt;
      r_i_done    <= w_enter_resp & ~w_rsp_d;
      r_i_err     <= w_enter_resp & ~w_rsp_d & w_rsp_err;
      r_d_done    <= w_enter_resp & w_rsp_d;
      r_d_err     <= w_enter_resp & w_rsp_d & w_rsp_err;
      if (w_enter_resp && !w_rsp_d)
        r_i_rdata <= w_rsp_err ? 32'd0 : w_ext;
      // a successful store leaves the data port's last load result in place
      if (w_enter_resp && w_rsp_d && (w_rsp_err || !w_rsp_wr))
        r_d_rdata <= w_rsp_err ? 32'd0 : w_ext;
    end
  end

  assign bus.RAM_RE    = r_ram_re;
  assign bus.RAM_WE    = r_ram_we;
  assign bus.RAM_RADDR = r_ram_raddr;
  assign bus.RAM_WADDR = r_ram_waddr;
  assign bus.RAM_WDATA = r_ram_wdata;
  assign bus.I_DONE    = r_i_done;
  assign bus.I_ERR     = r_i_err;
  assign bus.I_RDATA   = r_i_rdata;
  assign bus.D_DONE    = r_d_done;
  assign bus.D_ERR     = r_d_err;
  assign bus.D_RDATA   = r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: a byte-RAM model, a shadow memory and
// response/RAM-access scoreboards filled at drive time and drained at DONE.
module tb_mem_arbiter_ctrl;
  localparam int MEM = 1536;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  mem_arbiter_ctrl_if bus();

  mem_arbiter_ctrl #(.MEM_BYTES(MEM)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct { bit is_d; bit err; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { int cyc; bit we; logic [10:0] addr; logic [7:0] data; } ram_t;

  rsp_t        rsp_q[$];
  ram_t        ram_q[$];
  logic [7:0]  ram    [0:2047];
  logic [7:0]  shadow [0:2047];
  logic [31:0] hold_d;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      32'h200: return 8'h80;
      32'h201: return 8'h34;
      32'h202: return 8'hF1;
      default: return 8'((i * 7 + 3) & 255);
    endcase
  endfunction

  // synchronous byte RAM: data appears the cycle after RE
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] <= init_byte(i);
    forever begin
      @(posedge CLK);
      if (bus.RAM_WE) ram[bus.RAM_WADDR] <= bus.RAM_WDATA;
      if (bus.RAM_RE) bus.RAM_RDATA <= ram[bus.RAM_RADDR];
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit model_err(input logic [10:0] a, input logic [1:0] sz);
    return (sz == 2'b11) || (int'(a) >= MEM) || (int'(a) + nbytes(sz) - 1 >= MEM);
  endfunction

  function automatic logic [31:0] model_read(input logic [10:0] a, input logic [1:0] sz, input bit uns);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < nbytes(sz); k++) v[8*k +: 8] = shadow[int'(a) + k];
    if (sz == 2'b00 && !uns) v[31:8] = {24{v[7]}};
    if (sz == 2'b01 && !uns) v[31:16] = {16{v[15]}};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_xfer(input bit is_d, input bit wr, input bit uns, input logic [1:0] sz,
                             input logic [10:0] a, input logic [31:0] wd, input bit timed);
    rsp_t r;
    ram_t m;
    int   n = nbytes(sz);
    r.is_d = is_d;
    r.err  = model_err(a, sz);
    r.cyc  = 0;
    if (r.err) begin
      r.rdata = 32'd0;
      if (timed) r.cyc = 1;
    end else if (wr) begin
      r.rdata = hold_d;
      if (timed) r.cyc = n + 1;
      for (int k = 0; k < n; k++) begin
        shadow[int'(a) + k] = wd[8*k +: 8];
        if (timed) begin
          m.cyc = 1 + k; m.we = 1'b1; m.addr = 11'(int'(a) + k); m.data = wd[8*k +: 8];
          ram_q.push_back(m);
        end
      end
    end else begin
      r.rdata = model_read(a, sz, uns);
      if (timed) begin
        r.cyc = n + 2;
        for (int k = 0; k < n; k++) begin
          m.cyc = 1 + k; m.we = 1'b0; m.addr = 11'(int'(a) + k); m.data = 8'd0;
          ram_q.push_back(m);
        end
      end
    end
    if (is_d && (r.err || !wr)) hold_d = r.rdata;
    rsp_q.push_back(r);
  endtask

  task automatic drive(input bit is_d, input bit wr, input bit uns, input logic [1:0] sz,
                       input logic [10:0] a, input logic [31:0] wd);
    if (is_d) begin
      bus.D_REQ = 1'b1; bus.D_WR = wr; bus.D_UNSIGNED = uns;
      bus.D_SIZE = sz; bus.D_ADDR = a; bus.D_WDATA = wd;
    end else begin
      bus.I_REQ = 1'b1; bus.I_ADDR = a;
    end
  endtask

  task automatic run(input bit hold, input bit chk_ram, input int budget);
    int   cyc = 0;
    rsp_t r;
    ram_t m;
    while (rsp_q.size() != 0) begin
      @(negedge CLK);
      cyc++;
      if (cyc > budget) begin
        check("timeout_pending", 32'(rsp_q.size()), 32'd0);
        rsp_q.delete(); ram_q.delete();
        bus.I_REQ = 1'b0; bus.D_REQ = 1'b0;
        break;
      end
      if (bus.RAM_RE || bus.RAM_WE) begin
        check("re_we_excl", 32'(bus.RAM_RE & bus.RAM_WE), 32'd0);
        if (chk_ram) begin
          if (ram_q.size() == 0) check("ram_unexpected_cycle", 32'(cyc), 32'd0);
          else begin
            m = ram_q.pop_front();
            check("ram_cycle", 32'(cyc), 32'(m.cyc));
            check("ram_we", 32'(bus.RAM_WE), 32'(m.we));
            check("ram_addr", 32'(m.we ? bus.RAM_WADDR : bus.RAM_RADDR), 32'(m.addr));
            if (m.we) check("ram_wdata", 32'(bus.RAM_WDATA), 32'(m.data));
          end
        end
      end
      if (bus.I_DONE || bus.D_DONE) begin
        check("single_done", 32'(bus.I_DONE & bus.D_DONE), 32'd0);
        r = rsp_q.pop_front();
        check("done_port_is_d", 32'(bus.D_DONE), 32'(r.is_d));
        check("err", 32'(r.is_d ? bus.D_ERR : bus.I_ERR), 32'(r.err));
        check("rdata", r.is_d ? bus.D_RDATA : bus.I_RDATA, r.rdata);
        if (r.cyc != 0) check("done_cycle", 32'(cyc), 32'(r.cyc));
        if (!hold) begin
          if (r.is_d) bus.D_REQ = 1'b0;
          else        bus.I_REQ = 1'b0;
        end
        if (rsp_q.size() == 0) begin
          bus.I_REQ = 1'b0; bus.D_REQ = 1'b0;
        end
      end
    end
    if (chk_ram) check("ram_accesses_left", 32'(ram_q.size()), 32'd0);
    @(negedge CLK);
    check("done_one_cycle", {30'd0, bus.I_DONE, bus.D_DONE}, 32'd0);
  endtask

  task automatic one(input bit is_d, input bit wr, input bit uns, input logic [1:0] sz,
                     input logic [10:0] a, input logic [31:0] wd);
    drive(is_d, wr, uns, sz, a, wd);
    expect_xfer(is_d, wr, uns, sz, a, wd, 1'b1);
    run(1'b0, 1'b1, 20);
  endtask

  initial begin
    bus.I_REQ = 1'b0; bus.I_ADDR = '0;
    bus.D_REQ = 1'b0; bus.D_WR = 1'b0; bus.D_UNSIGNED = 1'b0;
    bus.D_SIZE = '0;  bus.D_ADDR = '0; bus.D_WDATA = '0;
    hold_d = 32'd0;
    for (int i = 0; i < 2048; i++) shadow[i] = init_byte(i);

    repeat (3) @(negedge CLK);
    check("rst_i_done", 32'(bus.I_DONE), 32'd0);
    check("rst_i_err", 32'(bus.I_ERR), 32'd0);
    check("rst_i_rdata", bus.I_RDATA, 32'd0);
    check("rst_d_done", 32'(bus.D_DONE), 32'd0);
    check("rst_d_err", 32'(bus.D_ERR), 32'd0);
    check("rst_d_rdata", bus.D_RDATA, 32'd0);
    check("rst_ram_re_we", {30'd0, bus.RAM_RE, bus.RAM_WE}, 32'd0);
    check("rst_ram_raddr", 32'(bus.RAM_RADDR), 32'd0);
    check("rst_ram_waddr", 32'(bus.RAM_WADDR), 32'd0);
    check("rst_ram_wdata", 32'(bus.RAM_WDATA), 32'd0);
    RST_N = 1'b1;

    // both held from reset: D, I, D, I
    drive(1'b1, 1'b0, 1'b0, 2'b00, 11'h200, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'b10, 11'h100, 32'd0);
    expect_xfer(1'b1, 1'b0, 1'b0, 2'b00, 11'h200, 32'd0, 1'b0);
    expect_xfer(1'b0, 1'b0, 1'b0, 2'b10, 11'h100, 32'd0, 1'b0);
    expect_xfer(1'b1, 1'b0, 1'b0, 2'b00, 11'h200, 32'd0, 1'b0);
    expect_xfer(1'b0, 1'b0, 1'b0, 2'b10, 11'h100, 32'd0, 1'b0);
    run(1'b1, 1'b0, 60);

    one(1'b0, 1'b0, 1'b0, 2'b10, 11'h100, 32'd0);          // fetch 0x44332211
    one(1'b1, 1'b1, 1'b0, 2'b10, 11'h5FC, 32'hDEADBEEF);   // store at top word
    one(1'b1, 1'b0, 1'b0, 2'b10, 11'h5FC, 32'd0);
    one(1'b1, 1'b0, 1'b1, 2'b00, 11'h200, 32'd0);
    one(1'b1, 1'b0, 1'b0, 2'b00, 11'h200, 32'd0);
    one(1'b1, 1'b0, 1'b0, 2'b01, 11'h201, 32'd0);
    one(1'b1, 1'b0, 1'b1, 2'b01, 11'h201, 32'd0);
    one(1'b1, 1'b0, 1'b1, 2'b00, 11'h5FF, 32'd0);
    one(1'b1, 1'b0, 1'b0, 2'b10, 11'h5FD, 32'd0);          // errors
    one(1'b1, 1'b0, 1'b0, 2'b00, 11'h600, 32'd0);
    one(1'b1, 1'b1, 1'b0, 2'b11, 11'h010, 32'h12345678);
    one(1'b1, 1'b0, 1'b0, 2'b01, 11'h5FF, 32'd0);
    one(1'b0, 1'b0, 1'b0, 2'b10, 11'h5FD, 32'd0);
    one(1'b1, 1'b1, 1'b0, 2'b01, 11'h3FF, 32'h0000C35A);   // misaligned half store
    one(1'b1, 1'b0, 1'b1, 2'b10, 11'h3FE, 32'd0);

    // reset in cycle 2 of a word write
    drive(1'b1, 1'b1, 1'b0, 2'b10, 11'h300, 32'hA1B2C3D4);
    @(negedge CLK);
    check("abort_we_c1", 32'(bus.RAM_WE), 32'd1);
    check("abort_waddr_c1", 32'(bus.RAM_WADDR), 32'h300);
    check("abort_wdata_c1", 32'(bus.RAM_WDATA), 32'hD4);
    @(negedge CLK);
    check("abort_we_c2", 32'(bus.RAM_WE), 32'd1);
    check("abort_wdata_c2", 32'(bus.RAM_WDATA), 32'hC3);
    RST_N = 1'b0;
    #1;
    check("abort_we_fall", 32'(bus.RAM_WE), 32'd0);
    check("abort_no_done", 32'(bus.D_DONE), 32'd0);
    bus.D_REQ = 1'b0;
    shadow[32'h300] = 8'hD4;
    hold_d = 32'd0;
    repeat (2) @(negedge CLK);
    check("abort_still_no_done", 32'(bus.D_DONE), 32'd0);
    check("abort_d_rdata_cleared", bus.D_RDATA, 32'd0);
    RST_N = 1'b1;

    // tie right after reset: D first again, then I
    drive(1'b1, 1'b0, 1'b1, 2'b01, 11'h300, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'b10, 11'h100, 32'd0);
    expect_xfer(1'b1, 1'b0, 1'b1, 2'b01, 11'h300, 32'd0, 1'b1);
    expect_xfer(1'b0, 1'b0, 1'b0, 2'b10, 11'h100, 32'd0, 1'b0);
    ram_q.delete();
    run(1'b0, 1'b0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
